mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage: LW, LWPOI, SW, CALL push, RET pop). Each requester uses a level request / one-cycle done handshake. Grants are round-robin, and one access is outstanding at a time. The block registers every memory-side signal and sits between the control-unit-driven datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between instruction fetch and data access
// Optional feature: define ARB_TIMEOUT_EN to abort an access after TIMEOUT wait cycles (err pulses with done).
// Ports:
//   clk_i, reset_i (async, active-high)
//   if_req_i/if_addr_i -> if_rdata_o/if_done_o        fetch requester, level req / one-cycle done
//   d_req_i/d_we_i/d_addr_i/d_wdata_i -> d_rdata_o/d_done_o   data requester
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_rdata_i/mem_ready_i   registered memory port
//   busy_o (FSM not idle), err_o (access timed out, with done)
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_done_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_done_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i,
   output logic              busy_o,
   output logic              err_o
);
   typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D, RESP} state_t;
   state_t state_q, grant_d;
   logic last_d_q;
   logic if_v, d_v, pick_d, fin;
   // A port showing done this cycle has just been served; its still-high request is stale.
   assign if_v    = if_req_i & ~if_done_o;
   assign d_v     = d_req_i & ~d_done_o;
   assign pick_d  = d_v & (~if_v | ~last_d_q);
   assign grant_d = pick_d ? GRANT_D : GRANT_IF;
   assign busy_o  = state_q != IDLE;
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
   // Abort on the wait cycle that would bring the counter to TIMEOUT; mem_ready still wins.
   assign fin = mem_ready_i | (cnt_q == CW'(TIMEOUT - 1));
`else
   assign fin   = mem_ready_i;
   assign err_o = 1'b0;
`endif
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b1;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_rdata_o  <= '0;
         d_rdata_o   <= '0;
         if_done_o   <= 1'b0;
         d_done_o    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= '0;
         err_o       <= 1'b0;
`endif
      end else begin
         if_done_o <= 1'b0;
         d_done_o  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         err_o     <= 1'b0;
`endif
         case (state_q)
            GRANT_IF, GRANT_D: begin
               if (mem_ready_i && state_q == GRANT_IF) if_rdata_o <= mem_rdata_i;
               if (mem_ready_i && state_q == GRANT_D && !mem_we_o) d_rdata_o <= mem_rdata_i;
               if (fin) begin
                  state_q   <= RESP;
                  mem_en_o  <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if_done_o <= state_q == GRANT_IF;
                  d_done_o  <= state_q == GRANT_D;
               end
`ifdef ARB_TIMEOUT_EN
               err_o <= fin & ~mem_ready_i;
               cnt_q <= fin ? cnt_q : cnt_q + 1'b1;
`endif
            end
            // IDLE and RESP both arbitrate, so a waiting port is granted right after the done cycle.
            default:
               if (if_v || d_v) begin
                  state_q     <= grant_d;
                  last_d_q    <= pick_d;
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= pick_d & d_we_i;
                  mem_addr_o  <= pick_d ? d_addr_i : if_addr_i;
                  mem_wdata_o <= pick_d ? d_wdata_i : '0;
`ifdef ARB_TIMEOUT_EN
                  cnt_q       <= '0;
`endif
               end else
                  state_q <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with directed vectors
module tb_mem_port_arbiter;
   logic        clk_i = 0, reset_i = 0;
   logic        if_req_i = 0, d_req_i = 0, d_we_i = 0, mem_ready_i = 0;
   logic [31:0] if_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, mem_rdata_i = 0;
   logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
   logic        if_done_o, d_done_o, mem_en_o, mem_we_o, busy_o, err_o;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;
   typedef struct {logic d; logic [31:0] rdata; logic err;} resp_t;
   grant_t gq[$];
   resp_t  rq[$];
   grant_t cur;
   resp_t  r;
   int n_vec = 0, n_err = 0;
   int wait_n = 0, wcnt = 0, en_cyc = 0, n = 0;
   logic rd_fix_en = 0, en_prev = 0;
   logic [31:0] rd_fix = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_grant(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      grant_t g;
      g.we = we; g.addr = addr; g.wdata = wdata;
      gq.push_back(g);
   endtask

   task automatic exp_resp(input logic d, input logic [31:0] rdata, input logic err);
      resp_t e;
      e.d = d; e.rdata = rdata; e.err = err;
      rq.push_back(e);
   endtask

   task automatic wait_done(input logic d, input string nm);
      int k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while ((d ? d_done_o : if_done_o) !== 1'b1 && k < 300);
      chk(nm, d ? d_done_o : if_done_o, 1);
   endtask

   task automatic pulse_reset;
      reset_i = 1;
      @(negedge clk_i);
      reset_i = 0;
      @(negedge clk_i);
   endtask

   // Memory model: ready after wait_n wait cycles, data = address + 0x100 unless overridden.
   always @(negedge clk_i) begin
      if (mem_en_o) begin
         if (wcnt >= wait_n) begin
            mem_ready_i = 1;
            mem_rdata_i = rd_fix_en ? rd_fix : mem_addr_o + 32'h100;
         end else begin
            mem_ready_i = 0;
            wcnt++;
         end
      end else begin
         mem_ready_i = 0;
         wcnt = 0;
      end
   end

   // Monitor: checks every grant and every done against the scoreboard queues.
   always @(negedge clk_i) begin
      if (!reset_i) begin
         if (mem_en_o && !en_prev) begin
            chk("grant_expected", gq.size() > 0, 1);
            if (gq.size() > 0) begin
               cur = gq.pop_front();
               chk("grant_we", mem_we_o, cur.we);
               chk("grant_addr", mem_addr_o, cur.addr);
               chk("grant_wdata", mem_wdata_o, cur.wdata);
            end
         end else if (mem_en_o) begin
            chk("hold_we", mem_we_o, cur.we);
            chk("hold_addr", mem_addr_o, cur.addr);
            chk("hold_wdata", mem_wdata_o, cur.wdata);
         end
         if (if_done_o || d_done_o) begin
            chk("done_expected", rq.size() > 0, 1);
            chk("done_single_port", if_done_o & d_done_o, 0);
            if (rq.size() > 0) begin
               r = rq.pop_front();
               chk("done_port", d_done_o, r.d);
               chk("done_rdata", r.d ? d_rdata_o : if_rdata_o, r.rdata);
               chk("done_err", err_o, r.err);
            end
         end else if (err_o)
            chk("err_without_done", err_o, 0);
      end
      en_prev = mem_en_o;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
      $fatal(1);
   end

   initial begin
      reset_i = 1;
      repeat (2) @(negedge clk_i);
      chk("rst_mem_en", mem_en_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_if_rdata", if_rdata_o, 0);
      chk("rst_d_rdata", d_rdata_o, 0);
      chk("rst_done", {if_done_o, d_done_o}, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      reset_i = 0;
      @(negedge clk_i);

      // Single fetch, ready on first sample
      rd_fix_en = 1; rd_fix = 32'hDEADBEEF; wait_n = 0;
      exp_grant(0, 32'h10, 0);
      exp_resp(0, 32'hDEADBEEF, 0);
      if_addr_i = 32'h10; if_req_i = 1;
      @(negedge clk_i);
      chk("t1_en_after_grant", mem_en_o, 1);
      chk("t1_busy", busy_o, 1);
      @(negedge clk_i);
      chk("t1_en_drop", mem_en_o, 0);
      chk("t1_if_done", if_done_o, 1);
      if_req_i = 0;
      @(negedge clk_i);
      chk("t1_done_one_cycle", if_done_o, 0);
      chk("t1_rdata_held", if_rdata_o, 32'hDEADBEEF);
      chk("t1_idle", busy_o, 0);
      rd_fix_en = 0;

      // Data write with two wait cycles
      wait_n = 2;
      exp_grant(1, 32'h40, 32'h1234);
      exp_resp(1, 32'h0, 0);
      d_we_i = 1; d_addr_i = 32'h40; d_wdata_i = 32'h1234; d_req_i = 1;
      en_cyc = 0; n = 0;
      do begin
         @(negedge clk_i);
         if (mem_en_o) en_cyc++;
         n++;
      end while (d_done_o !== 1'b1 && n < 50);
      chk("t2_d_done", d_done_o, 1);
      chk("t2_en_cycles", en_cyc, 3);
      d_req_i = 0; d_we_i = 0;
      @(negedge clk_i);
      chk("t2_done_one_cycle", d_done_o, 0);
      chk("t2_d_rdata_kept", d_rdata_o, 0);

      // Simultaneous requests from reset: IF first, one idle cycle, then data
      pulse_reset();
      wait_n = 0;
      exp_grant(0, 32'h10, 0);
      exp_grant(0, 32'h44, 32'h1234);
      exp_resp(0, 32'h110, 0);
      exp_resp(1, 32'h144, 0);
      if_addr_i = 32'h10; d_addr_i = 32'h44; d_wdata_i = 32'h1234;
      if_req_i = 1; d_req_i = 1;
      @(negedge clk_i);
      chk("t3_if_en", mem_en_o, 1);
      @(negedge clk_i);
      chk("t3_gap_en", mem_en_o, 0);
      chk("t3_if_done", if_done_o, 1);
      if_req_i = 0;
      @(negedge clk_i);
      chk("t3_d_en", mem_en_o, 1);
      chk("t3_busy_through", busy_o, 1);
      @(negedge clk_i);
      chk("t3_d_done", d_done_o, 1);
      d_req_i = 0;
      @(negedge clk_i);

      // Reset in the middle of a fetch
      pulse_reset();
      wait_n = 5;
      exp_grant(0, 32'h30, 0);
      if_addr_i = 32'h30; if_req_i = 1;
      @(negedge clk_i);
      chk("t4_en", mem_en_o, 1);
      @(negedge clk_i);
      reset_i = 1;
      #1;
      chk("t4_async_en", mem_en_o, 0);
      chk("t4_async_busy", busy_o, 0);
      if_req_i = 0;
      @(negedge clk_i);
      reset_i = 0;
      chk("t4_if_rdata_clr", if_rdata_o, 0);
      repeat (3) @(negedge clk_i);
      wait_n = 0;
      exp_grant(0, 32'h34, 0);
      exp_grant(0, 32'h48, 32'h1234);
      exp_resp(0, 32'h134, 0);
      exp_resp(1, 32'h148, 0);
      if_addr_i = 32'h34; d_addr_i = 32'h48; d_we_i = 0;
      if_req_i = 1; d_req_i = 1;
      wait_done(0, "t4_if_done");
      if_req_i = 0;
      wait_done(1, "t4_d_done");
      d_req_i = 0;
      @(negedge clk_i);

      // Continuous contention: grants alternate IF, D, IF, D, IF, D
      pulse_reset();
      d_wdata_i = 32'h55;
      exp_grant(0, 32'h20, 0);  exp_resp(0, 32'h120, 0);
      exp_grant(0, 32'h80, 32'h55); exp_resp(1, 32'h180, 0);
      exp_grant(0, 32'h24, 0);  exp_resp(0, 32'h124, 0);
      exp_grant(1, 32'h84, 32'h55); exp_resp(1, 32'h180, 0);
      exp_grant(0, 32'h28, 0);  exp_resp(0, 32'h128, 0);
      exp_grant(0, 32'h88, 32'h55); exp_resp(1, 32'h188, 0);
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               if_addr_i = 32'h20 + 32'(4 * i);
               if_req_i = 1;
               wait_done(0, "t5_if_done");
            end
            if_req_i = 0;
         end
         begin
            for (int j = 0; j < 3; j++) begin
               d_addr_i = 32'h80 + 32'(4 * j);
               d_we_i = (j == 1);
               d_req_i = 1;
               wait_done(1, "t5_d_done");
            end
            d_req_i = 0; d_we_i = 0;
         end
      join
      @(negedge clk_i);

      // Memory never ready
      wait_n = 1000;
      exp_grant(0, 32'h70, 32'h55);
      d_addr_i = 32'h70; d_we_i = 0;
`ifdef ARB_TIMEOUT_EN
      exp_resp(1, 32'h188, 1);
      d_req_i = 1;
      en_cyc = 0; n = 0;
      do begin
         @(negedge clk_i);
         if (mem_en_o) en_cyc++;
         n++;
      end while (d_done_o !== 1'b1 && n < 100);
      chk("t6_d_done", d_done_o, 1);
      chk("t6_err", err_o, 1);
      chk("t6_en_cycles", en_cyc, 15);
      chk("t6_d_rdata_kept", d_rdata_o, 32'h188);
      d_req_i = 0;
      @(negedge clk_i);
      chk("t6_err_one_cycle", err_o, 0);
`else
      d_req_i = 1;
      repeat (100) @(negedge clk_i);
      chk("t6_still_waiting", mem_en_o, 1);
      chk("t6_still_busy", busy_o, 1);
      chk("t6_no_err", err_o, 0);
      d_req_i = 0;
      pulse_reset();
`endif
      wait_n = 0;
      repeat (2) @(negedge clk_i);
      chk("end_grant_queue", gq.size(), 0);
      chk("end_resp_queue", rq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
